// File: rtl/decode_stage_if.sv
// Fetch/decode/execute bundle for decode_stage; master is the decode side, slave is its environment.
// Perf counter signals exist only when DECODE_PERF_CNT_EN is defined.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic [4:0]      rf_rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_target;
  logic            out_illegal;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]     perf_decoded;
  logic [31:0]     perf_stall;
`endif

  modport master (
    input  in_valid, in_instr, in_pc, flush, rs1_data, out_ready,
    output in_ready, rf_rs1_addr, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
    output out_rd, out_rs1, out_rs2, out_imm, out_target, out_illegal,
    output redirect_valid, redirect_pc
`ifdef DECODE_PERF_CNT_EN
    , output perf_decoded, perf_stall
`endif
  );

  modport slave (
    output in_valid, in_instr, in_pc, flush, rs1_data, out_ready,
    input  in_ready, rf_rs1_addr, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
    input  out_rd, out_rs1, out_rs2, out_imm, out_target, out_illegal,
    input  redirect_valid, redirect_pc
`ifdef DECODE_PERF_CNT_EN
    , input perf_decoded, perf_stall
`endif
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, JAL redirect and two-cycle JALR.
// Define DECODE_PERF_CNT_EN to add the perf_decoded/perf_stall counters.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 16
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.master bus
);
  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_JALR_WAIT = 1'b1;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] target;
    logic            illegal;
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

  logic [0:0]      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  bundle_t         bundle_q, bundle_d, dec_s;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [4:0]      rf_rs1_addr_q, rf_rs1_addr_d;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic signed [31:0] imm32_s;
  logic            in_ready_s;
  logic            accept_s;
  logic [XLEN-1:0] jalr_sum_s;

  assign opcode_s   = bus.in_instr[6:0];
  assign funct3_s   = bus.in_instr[14:12];
  assign in_ready_s = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign jalr_sum_s = bus.rs1_data + bundle_q.imm;

  // Field extraction; fields a format does not use stay zero.
  always_comb begin
    dec_s        = {BUNDLE_W{1'b0}};
    imm32_s      = 32'sd0;
    dec_s.pc     = bus.in_pc;
    dec_s.opcode = opcode_s;
    case (opcode_s)
      OP_REG: begin
        dec_s.funct3 = funct3_s;
        dec_s.funct7 = bus.in_instr[31:25];
        dec_s.rd     = bus.in_instr[11:7];
        dec_s.rs1    = bus.in_instr[19:15];
        dec_s.rs2    = bus.in_instr[24:20];
      end
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        dec_s.funct3 = funct3_s;
        dec_s.rd     = bus.in_instr[11:7];
        dec_s.rs1    = bus.in_instr[19:15];
        // Only the shift-immediate forms carry an unsigned shamt.
        if (opcode_s == OP_IMM && (funct3_s == 3'b001 || funct3_s == 3'b101)) begin
          imm32_s = {27'd0, bus.in_instr[24:20]};
        end else begin
          imm32_s = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        end
      end
      OP_STORE: begin
        dec_s.funct3 = funct3_s;
        dec_s.rs1    = bus.in_instr[19:15];
        dec_s.rs2    = bus.in_instr[24:20];
        imm32_s      = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec_s.funct3 = funct3_s;
        dec_s.rs1    = bus.in_instr[19:15];
        dec_s.rs2    = bus.in_instr[24:20];
        imm32_s      = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                        bus.in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_s.rd = bus.in_instr[11:7];
        imm32_s  = {bus.in_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_s.rd = bus.in_instr[11:7];
        imm32_s  = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                    bus.in_instr[30:21], 1'b0};
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
    dec_s.imm = XLEN'(imm32_s);
    if (opcode_s == OP_BRANCH) begin
      dec_s.target = bus.in_pc + dec_s.imm[PC_W-1:0];
    end else begin
      dec_s.target = {PC_W{1'b0}};
    end
  end

  // Handshake/FSM next state; flush wins, then JALR completion, then accept, then drain.
  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q;
    bundle_d         = bundle_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    rf_rs1_addr_d    = rf_rs1_addr_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_RUN;
    end else if (state_q == ST_JALR_WAIT) begin
      out_valid_d      = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = {jalr_sum_s[PC_W-1:1], 1'b0};
      state_d          = ST_RUN;
    end else if (accept_s) begin
      bundle_d      = dec_s;
      rf_rs1_addr_d = dec_s.rs1;
      if (opcode_s == OP_JALR) begin
        out_valid_d = 1'b0;
        state_d     = ST_JALR_WAIT;
      end else begin
        out_valid_d = 1'b1;
        if (opcode_s == OP_JAL) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = bus.in_pc + dec_s.imm[PC_W-1:0];
        end else begin
          redirect_valid_d = 1'b0;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      out_valid_q      <= 1'b0;
      bundle_q         <= {BUNDLE_W{1'b0}};
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {PC_W{1'b0}};
      rf_rs1_addr_q    <= 5'd0;
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      bundle_q         <= bundle_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      rf_rs1_addr_q    <= rf_rs1_addr_d;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.rf_rs1_addr    = rf_rs1_addr_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = bundle_q.pc;
  assign bus.out_opcode     = bundle_q.opcode;
  assign bus.out_funct3     = bundle_q.funct3;
  assign bus.out_funct7     = bundle_q.funct7;
  assign bus.out_rd         = bundle_q.rd;
  assign bus.out_rs1        = bundle_q.rs1;
  assign bus.out_rs2        = bundle_q.rs2;
  assign bus.out_imm        = bundle_q.imm;
  assign bus.out_target     = bundle_q.target;
  assign bus.out_illegal    = bundle_q.illegal;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_q, perf_decoded_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Free-running event counters, wrapping naturally.
  always_comb begin
    perf_decoded_d = perf_decoded_q + (accept_s ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + ((bus.in_valid && !in_ready_s) ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign bus.perf_decoded = perf_decoded_q;
  assign bus.perf_stall   = perf_stall_q;
`endif
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised RV32I decode stage placed between the fetch stage and the register-file/ALU.
- Decodes every base opcode into register indices, funct fields and a sign-extended immediate.
- Computes control-flow targets and redirects fetch for JAL/JALR.
- Provides a valid/ready handshake on both sides, plus flush and a two-cycle JALR sequence that waits for the register-file read of rs1.

Parameters:
- XLEN, 32, datapath/immediate width (≥32; immediates sign-extended to XLEN).
- PC_W, 16, program-counter width; all PC arithmetic is truncated to PC_W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- flush  in  1  kill held/incoming instruction (from branch resolution).
- rf_rs1_addr  out  5  register-file read address (registered out_rs1).
- rs1_data  in  XLEN  register-file rs1 value, valid one cycle after rf_rs1_addr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute stage accepts.
- out_pc  out  PC_W  PC of decoded instruction.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12], 0 for U/J.
- out_funct7  out  7  instr[31:25] for R-type, else 0.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when unused by format.
- out_imm  out  XLEN  final immediate.
- out_target  out  PC_W  pc+B-imm for branches, else 0.
- out_illegal  out  1  opcode not in RV32I base set.
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_pc  out  PC_W  jump target.

Behaviour:
- Reset:
  - All out_* registers, redirect_valid, redirect_pc and rf_rs1_addr are 0.
  - State is RUN; in_ready is driven combinationally, so it reads 1 once reset is released.
- States: RUN, JALR_WAIT.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready) registers all fields at the edge, giving 1-cycle latency to out_valid.
- Formats:
  - R 0110011
  - I 0000011/0010011/1100111
  - S 0100011
  - B 1100011
  - U 0110111/0010111
  - J 1101111
  - FENCE 0001111 and SYSTEM 1110011 decode as I-type.
  - Anything else sets out_illegal=1; all other decoded fields are 0 and no redirect is issued.
- Immediates:
  - I/S/B/J are sign-extended to XLEN; U is {instr[31:12],12'b0} sign-extended.
  - A zero-extended shamt instr[24:20] is used only for opcode 0010011 with funct3 001/101; loads always use the I-immediate.
- rd is 0 for S/B. rs1 is 0 for U/J. rs2 is 0 except for R/S/B.
- JAL: on accept, out_valid=1 next cycle. redirect_valid pulses in that same cycle with redirect_pc=(pc+J-imm)[PC_W-1:0].
- JALR:
  - On accept, go to JALR_WAIT with out_valid=0; in_ready is 0 while in JALR_WAIT.
  - In JALR_WAIT, rs1_data is valid. Next edge: redirect_pc=((rs1_data+imm)&~1)[PC_W-1:0], redirect_valid=1 for one cycle, out_valid=1, state→RUN.
- Branches: out_target=(pc+B-imm)[PC_W-1:0]; no redirect (the execute stage resolves).
- Stall: while out_valid && !out_ready, every out_* register holds and in_ready=0; no instruction is lost or duplicated.
- Drain: out_valid clears after out_ready handshake if no new accept occurs.
- Flush:
  - Has priority over everything.
  - Next edge: out_valid=0, state→RUN, redirect_valid=0; a same-cycle in_valid is dropped.
  - If flush arrives in JALR_WAIT, the JALR is discarded.
- Reset mid-operation returns all state to reset values immediately (async).
- Wrap-around: PC sums are modulo 2^PC_W and no overflow flag is produced.

Optional Feature:
DECODE_PERF_CNT_EN
- When defined, adds outputs perf_decoded[31:0] and perf_stall[31:0].
- perf_decoded counts accepted, non-flushed instructions.
- perf_stall counts cycles with in_valid && !in_ready.
- Both counters reset to 0, wrap at 2^32 and count independently of flush.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Test Plan:
1. addi x5,x1,-3 (0xFFD08293), pc 0x0100 → next cycle out_valid=1, rd=5, rs1=1, rs2=0, imm=0xFFFFFFFD, funct3=0, out_pc=0x0100.
2. jal x1,+8 (0x008000EF), pc 0x0040 → next cycle out_valid=1, redirect_valid=1 for exactly one cycle, redirect_pc=0x0048, rd=1.
3. jalr x0,4(x2) (0x00410067), rs1_data=0x00001233 → rf_rs1_addr=2, in_ready=0 for one cycle, then redirect_pc=0x1236, out_valid=1.
4. Three back-to-back addi instructions with out_ready=0 for 3 cycles → first bundle held stable, in_ready=0, all three later emerge in order with no duplicates.
5. flush asserted in the same cycle as accepting the jal from scenario 2 → out_valid stays 0, redirect_valid stays 0; again during JALR_WAIT → no redirect.
6. lh x3,-1(x4) (0xFFF21183) → imm=0xFFFFFFFF (not shamt 0x1F), funct3=1; opcode 0x7F → out_illegal=1, redirect_valid=0.
